irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Machine-mode interrupt source block; the trap *initiator* for the core's exception/CSR handler.
- Holds the timer (mtime/mtimecmp), software-interrupt bit, latched external interrupt lines and per-source enables.
- Prioritizes pending sources and raises a single interrupt request with an mcause value, using a req/ack handshake.
- Is memory-mapped on the data bus next to the core; tracks the in-service interrupt until the handler executes mret.

Parameters:
- N_EXT, 4, number of external interrupt input lines (1..16)
- TICK_DIV, 1, mtime increments once every TICK_DIV clocks (≥1)

Ports:
- clk  in  1  system clock
- reset_x  in  1  synchronous active-low reset
- bus_we  in  1  register write strobe
- bus_re  in  1  register read strobe
- bus_addr  in  5  byte offset (word aligned)
- bus_wdata  in  32  write data
- bus_rdata  out  32  read data, valid the cycle after bus_re
- ext_irq  in  N_EXT  external interrupt lines, rising-edge sensitive
- mie_global  in  1  mstatus.MIE from the exception handler
- irq_ack  in  1  core has taken the trap (one-cycle pulse)
- mret  in  1  core executed mret (one-cycle pulse)
- irq_req  out  1  interrupt request
- irq_cause  out  32  mcause for the request: bit31=1, code in [3:0]

Behaviour:
Register map, 32-bit word access only; unmapped reads return 0 and unmapped writes are ignored:
- 0x00: MSIP[0]
- 0x04/0x08: mtimecmp lo/hi
- 0x0C/0x10: mtime lo/hi
- 0x14: EXTPEND[N_EXT-1:0], write-1-to-clear
- 0x18: ENABLE, bit3=MSIE, bit7=MTIE, bit11=MEIE

Reset, applied at posedge clk while reset_x=0:
- mtime=0, mtimecmp=all ones, MSIP=0, EXTPEND=0, ENABLE=0.
- State=IDLE, irq_req=0, irq_cause=0, bus_rdata=0.
- Reset asserted mid-operation drops irq_req in the same edge; no pending state survives.

Timer:
- A prescale counter counts 0..TICK_DIV-1; mtime increments on its wrap.
- mtime is 64-bit and wraps to 0 silently.
- A bus write to either mtime half overrides the increment in that cycle; the other half is unchanged.
- MTIP = (mtime ≥ mtimecmp), unsigned 64-bit, combinational from registers. It clears only by rewriting mtimecmp or mtime.

External lines:
- ext_irq is registered once; a 0→1 on the registered line sets EXTPEND[i].
- If a W1C of bit i and a new edge on line i occur in the same cycle, the edge wins and the bit stays 1.
- MEIP = |EXTPEND.

Eligible sources:
- MEI = MEIP & MEIE; MSI = MSIP & MSIE; MTI = MTIP & MTIE.
- Fixed priority MEI > MSI > MTI, with codes 11, 3, 7.
- any = mie_global & (MEI | MSI | MTI).

FSM:
- IDLE: if any, go to REQ next cycle, with irq_req=1 and irq_cause latched from the highest-priority eligible source.
- REQ:
  - irq_cause is held stable.
  - irq_ack → SERVICE with irq_req=0.
  - If the latched source is no longer eligible and irq_ack=0 → IDLE with irq_req=0 (withdraw).
  - A higher-priority source arriving does not change cause until re-arbitration in IDLE.
- SERVICE: no new request; mret → IDLE. Nested interrupts are not supported.
- irq_ack outside REQ and mret outside SERVICE are ignored.
- Latency: eligible source at cycle N → irq_req=1 at cycle N+1.

Bus:
- bus_rdata is registered.
- A read and a write to the same address in the same cycle return the old value.

Decomposition:
- Shared package irq_pkg holds:
  - register offset constants;
  - cause codes CAUSE_MSI=3, CAUSE_MTI=7, CAUSE_MEI=11;
  - FSM state enum IDLE/REQ/SERVICE;
  - ENABLE bit positions.
- One natural sub-module, irq_timer: prescaler, mtime/mtimecmp, bus write of the timer words, MTIP output.

Test Plan:
- Reset and register defaults: hold reset_x=0 for 2 cycles, then read 0x04 and 0x08 → 0xFFFFFFFF; read 0x0C → 0; irq_req stays 0.
- Timer interrupt: TICK_DIV=1, write mtimecmp=20, ENABLE=0x80, mie_global=1 → irq_req rises the cycle after mtime reaches 20 with irq_cause=0x80000007; irq_ack → irq_req=0; mret → IDLE; the request re-fires while MTIP persists.
- Priority: set MSIP=1 and pulse ext_irq[2] in the same cycle with ENABLE=0x888 → cause 0x8000000B; after W1C of EXTPEND and the mret cycle → next request cause 0x80000003.
- Withdraw: raise MSI and enter REQ, then write MSIP=0 before irq_ack → irq_req=0 the next cycle; a later irq_ack is ignored and the FSM stays IDLE.
- Gating and service: mie_global=0 with a source pending → no request; set mie_global=1 → irq_req one cycle later; in SERVICE a new external edge is latched in EXTPEND but irq_req stays 0 until mret.
- Edge cases: W1C and a new edge on the same line in one cycle → bit remains 1; write mtime lo=0xFFFFFFFF, hi=0xFFFFFFFF → wraps to 0 on the next tick; assert reset_x=0 while in REQ → irq_req=0 at that edge.

Source files
------------

// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared register map, cause codes and FSM states for the interrupt controller
package irq_pkg;

  localparam logic [4:0] ADDR_MSIP        = 5'h00;
  localparam logic [4:0] ADDR_MTIMECMP_LO = 5'h04;
  localparam logic [4:0] ADDR_MTIMECMP_HI = 5'h08;
  localparam logic [4:0] ADDR_MTIME_LO    = 5'h0C;
  localparam logic [4:0] ADDR_MTIME_HI    = 5'h10;
  localparam logic [4:0] ADDR_EXTPEND     = 5'h14;
  localparam logic [4:0] ADDR_ENABLE      = 5'h18;

  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_MEI = 4'd11;

  localparam int EN_MSIE_BIT = 3;
  localparam int EN_MTIE_BIT = 7;
  localparam int EN_MEIE_BIT = 11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  // mcause for a machine interrupt: interrupt flag in bit 31, code in the low nibble
  function automatic logic [31:0] make_cause(input logic [3:0] code);
    return {1'b1, 27'd0, code};
  endfunction

endpackage

// File: rtl/irq_timer.sv
// rtl/irq_timer.sv - prescaled 64-bit mtime, mtimecmp registers and the MTIP compare
module irq_timer
  import irq_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic        i_clk,
  input  logic        i_reset_x,
  input  logic        i_bus_we,
  input  logic [4:0]  i_bus_addr,
  input  logic [31:0] i_bus_wdata,
  output logic [63:0] o_mtime,
  output logic [63:0] o_mtimecmp,
  output logic        o_mtip
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_presc;
  logic [63:0]   r_mtime;
  logic [63:0]   r_mtimecmp;
  logic          w_tick;

  assign w_tick = (r_presc == PRESC_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_reset_x) begin
      r_presc    <= '0;
      r_mtime    <= '0;
      r_mtimecmp <= '1;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      // a software write to either mtime half takes precedence over the tick
      if (i_bus_we && i_bus_addr == ADDR_MTIME_LO) begin
        r_mtime[31:0] <= i_bus_wdata;
      end else if (i_bus_we && i_bus_addr == ADDR_MTIME_HI) begin
        r_mtime[63:32] <= i_bus_wdata;
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
      end
      if (i_bus_we && i_bus_addr == ADDR_MTIMECMP_LO) begin
        r_mtimecmp[31:0] <= i_bus_wdata;
      end
      if (i_bus_we && i_bus_addr == ADDR_MTIMECMP_HI) begin
        r_mtimecmp[63:32] <= i_bus_wdata;
      end
    end
  end

  assign o_mtime    = r_mtime;
  assign o_mtimecmp = r_mtimecmp;
  assign o_mtip     = (r_mtime >= r_mtimecmp);

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - machine-mode interrupt sources, fixed-priority arbitration and req/ack/mret tracking
module irq_controller
  import irq_pkg::*;
#(
  parameter int N_EXT    = 4,
  parameter int TICK_DIV = 1
) (
  input  logic             i_clk,
  input  logic             i_reset_x,
  input  logic             i_bus_we,
  input  logic             i_bus_re,
  input  logic [4:0]       i_bus_addr,
  input  logic [31:0]      i_bus_wdata,
  output logic [31:0]      o_bus_rdata,
  input  logic [N_EXT-1:0] i_ext_irq,
  input  logic             i_mie_global,
  input  logic             i_irq_ack,
  input  logic             i_mret,
  output logic             o_irq_req,
  output logic [31:0]      o_irq_cause
);

  logic [63:0]      w_mtime;
  logic [63:0]      w_mtimecmp;
  logic             w_mtip;
  logic             r_msip;
  logic             r_msie;
  logic             r_mtie;
  logic             r_meie;
  logic [N_EXT-1:0] r_ext_q;
  logic [N_EXT-1:0] r_ext_prev;
  logic [N_EXT-1:0] r_extpend;
  logic [N_EXT-1:0] w_ext_edge;
  logic [N_EXT-1:0] w_ext_clr;
  logic [31:0]      r_rdata;
  logic [31:0]      w_rd_val;
  logic [31:0]      r_cause;
  logic [31:0]      w_cause_next;
  irq_state_e       r_state;
  irq_state_e       w_state_next;
  logic             w_mei;
  logic             w_msi;
  logic             w_mti;
  logic             w_any;
  logic             w_latched_elig;
  logic [3:0]       w_top_code;

  irq_timer #(
    .TICK_DIV(TICK_DIV)
  ) u_timer (
    .i_clk      (i_clk),
    .i_reset_x  (i_reset_x),
    .i_bus_we   (i_bus_we),
    .i_bus_addr (i_bus_addr),
    .i_bus_wdata(i_bus_wdata),
    .o_mtime    (w_mtime),
    .o_mtimecmp (w_mtimecmp),
    .o_mtip     (w_mtip)
  );

  // a fresh edge is OR-ed in after the clear so it survives a simultaneous W1C
  assign w_ext_edge = r_ext_q & ~r_ext_prev;
  assign w_ext_clr  = (i_bus_we && i_bus_addr == ADDR_EXTPEND) ? i_bus_wdata[N_EXT-1:0] : '0;

  always_ff @(posedge i_clk) begin
    if (!i_reset_x) begin
      r_ext_q    <= '0;
      r_ext_prev <= '0;
      r_extpend  <= '0;
      r_msip     <= 1'b0;
      r_msie     <= 1'b0;
      r_mtie     <= 1'b0;
      r_meie     <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_ext_q    <= i_ext_irq;
      r_ext_prev <= r_ext_q;
      r_extpend  <= (r_extpend & ~w_ext_clr) | w_ext_edge;
      if (i_bus_we && i_bus_addr == ADDR_MSIP) begin
        r_msip <= i_bus_wdata[0];
      end
      if (i_bus_we && i_bus_addr == ADDR_ENABLE) begin
        r_msie <= i_bus_wdata[EN_MSIE_BIT];
        r_mtie <= i_bus_wdata[EN_MTIE_BIT];
        r_meie <= i_bus_wdata[EN_MEIE_BIT];
      end
      if (i_bus_re) begin
        r_rdata <= w_rd_val;
      end
    end
  end

  always_comb begin
    w_rd_val = '0;
    case (i_bus_addr)
      ADDR_MSIP:        w_rd_val[0] = r_msip;
      ADDR_MTIMECMP_LO: w_rd_val = w_mtimecmp[31:0];
      ADDR_MTIMECMP_HI: w_rd_val = w_mtimecmp[63:32];
      ADDR_MTIME_LO:    w_rd_val = w_mtime[31:0];
      ADDR_MTIME_HI:    w_rd_val = w_mtime[63:32];
      ADDR_EXTPEND:     w_rd_val[N_EXT-1:0] = r_extpend;
      ADDR_ENABLE: begin
        w_rd_val[EN_MSIE_BIT] = r_msie;
        w_rd_val[EN_MTIE_BIT] = r_mtie;
        w_rd_val[EN_MEIE_BIT] = r_meie;
      end
      default: ;
    endcase
  end

  assign w_mei = (|r_extpend) & r_meie;
  assign w_msi = r_msip & r_msie;
  assign w_mti = w_mtip & r_mtie;
  assign w_any = i_mie_global & (w_mei | w_msi | w_mti);

  always_comb begin
    w_top_code = CAUSE_MTI;
    if (w_mei) begin
      w_top_code = CAUSE_MEI;
    end else if (w_msi) begin
      w_top_code = CAUSE_MSI;
    end
  end

  always_comb begin
    w_latched_elig = 1'b0;
    case (r_cause[3:0])
      CAUSE_MEI: w_latched_elig = w_mei;
      CAUSE_MSI: w_latched_elig = w_msi;
      CAUSE_MTI: w_latched_elig = w_mti;
      default:   w_latched_elig = 1'b0;
    endcase
  end

  // the cause is captured only on IDLE->REQ; a later higher-priority source waits for re-arbitration
  always_comb begin
    w_state_next = r_state;
    w_cause_next = r_cause;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_next = REQ;
          w_cause_next = make_cause(w_top_code);
        end
      end
      REQ: begin
        if (i_irq_ack) begin
          w_state_next = SERVICE;
        end else if (!w_latched_elig) begin
          w_state_next = IDLE;
        end
      end
      SERVICE: begin
        if (i_mret) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_x) begin
      r_state <= IDLE;
      r_cause <= '0;
    end else begin
      r_state <= w_state_next;
      r_cause <= w_cause_next;
    end
  end

  assign o_irq_req   = (r_state == REQ);
  assign o_irq_cause = r_cause;
  assign o_bus_rdata = r_rdata;

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - directed and random stimulus against a reference model with a queued scoreboard
module tb_irq_controller;

  localparam int N_EXT    = 4;
  localparam int TICK_DIV = 1;
  localparam int PH_IDLE  = 0;
  localparam int PH_REQ   = 1;
  localparam int PH_SERV  = 2;

  logic             clk = 1'b0;
  logic             reset_x = 1'b0;
  logic             bus_we = 1'b0;
  logic             bus_re = 1'b0;
  logic [4:0]       bus_addr = '0;
  logic [31:0]      bus_wdata = '0;
  logic [31:0]      o_bus_rdata;
  logic [N_EXT-1:0] ext_irq = '0;
  logic             mie_global = 1'b0;
  logic             irq_ack = 1'b0;
  logic             mret = 1'b0;
  logic             o_irq_req;
  logic [31:0]      o_irq_cause;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] rd_q[$];
  logic [31:0] cause_q[$];

  logic [63:0]      m_mtime = '0;
  logic [63:0]      m_cmp = '1;
  int               m_presc = 0;
  logic             m_msip = 1'b0;
  logic [31:0]      m_enable = '0;
  logic [N_EXT-1:0] m_pend = '0;
  logic [N_EXT-1:0] m_ext_q = '0;
  logic [N_EXT-1:0] m_ext_prev = '0;
  int               m_phase = PH_IDLE;
  int               m_code = 0;

  irq_controller #(
    .N_EXT(N_EXT),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .i_clk       (clk),
    .i_reset_x   (reset_x),
    .i_bus_we    (bus_we),
    .i_bus_re    (bus_re),
    .i_bus_addr  (bus_addr),
    .i_bus_wdata (bus_wdata),
    .o_bus_rdata (o_bus_rdata),
    .i_ext_irq   (ext_irq),
    .i_mie_global(mie_global),
    .i_irq_ack   (irq_ack),
    .i_mret      (mret),
    .o_irq_req   (o_irq_req),
    .o_irq_cause (o_irq_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'h00:   return {31'd0, m_msip};
      5'h04:   return m_cmp[31:0];
      5'h08:   return m_cmp[63:32];
      5'h0C:   return m_mtime[31:0];
      5'h10:   return m_mtime[63:32];
      5'h14:   return {{(32-N_EXT){1'b0}}, m_pend};
      5'h18:   return m_enable;
      default: return 32'd0;
    endcase
  endfunction

  // one clock edge of the architectural behaviour: decisions use pre-edge state, then state moves on
  task automatic model_step();
    logic             mtip;
    logic             mei;
    logic             msi;
    logic             mti;
    logic             still;
    logic             tick;
    logic [N_EXT-1:0] edges;
    if (!reset_x) begin
      if (bus_re) rd_q.push_back(32'd0);
      m_mtime = '0; m_cmp = '1; m_presc = 0; m_msip = 1'b0; m_enable = '0;
      m_pend = '0; m_ext_q = '0; m_ext_prev = '0; m_phase = PH_IDLE;
      return;
    end
    mtip = (m_mtime >= m_cmp);
    mei  = (m_pend != 0) && m_enable[11];
    msi  = m_msip && m_enable[3];
    mti  = mtip && m_enable[7];
    if (bus_re) rd_q.push_back(m_read(bus_addr));
    if (m_phase == PH_IDLE) begin
      if (mie_global && (mei || msi || mti)) begin
        m_code  = mei ? 11 : (msi ? 3 : 7);
        m_phase = PH_REQ;
        cause_q.push_back(32'h8000_0000 | 32'(m_code));
      end
    end else if (m_phase == PH_REQ) begin
      still = (m_code == 11 && mei) || (m_code == 3 && msi) || (m_code == 7 && mti);
      if (irq_ack) m_phase = PH_SERV;
      else if (!still) m_phase = PH_IDLE;
    end else if (mret) begin
      m_phase = PH_IDLE;
    end
    edges = m_ext_q & ~m_ext_prev;
    if (bus_we && bus_addr == 5'h14) m_pend = m_pend & ~bus_wdata[N_EXT-1:0];
    m_pend     = m_pend | edges;
    m_ext_prev = m_ext_q;
    m_ext_q    = ext_irq;
    if (bus_we && bus_addr == 5'h00) m_msip = bus_wdata[0];
    if (bus_we && bus_addr == 5'h04) m_cmp[31:0] = bus_wdata;
    if (bus_we && bus_addr == 5'h08) m_cmp[63:32] = bus_wdata;
    if (bus_we && bus_addr == 5'h18) m_enable = bus_wdata & 32'h0000_0888;
    tick    = (m_presc == TICK_DIV - 1);
    m_presc = tick ? 0 : m_presc + 1;
    if (bus_we && bus_addr == 5'h0C) m_mtime[31:0] = bus_wdata;
    else if (bus_we && bus_addr == 5'h10) m_mtime[63:32] = bus_wdata;
    else if (tick) m_mtime = m_mtime + 64'd1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    logic        prev_req;
    logic        saw_re;
    logic [31:0] e;
    prev_req = 1'b0;
    forever begin
      @(posedge clk);
      saw_re = bus_re;
      @(negedge clk);
      if (saw_re) begin
        if (rd_q.size() == 0) chk("mon_rd_expected", 32'(rd_q.size()), 32'd1);
        else begin
          e = rd_q.pop_front();
          chk("mon_rdata", o_bus_rdata, e);
        end
      end
      chk("mon_req_level", {31'd0, o_irq_req}, {31'd0, (m_phase == PH_REQ)});
      if (o_irq_req && !prev_req) begin
        if (cause_q.size() == 0) chk("mon_cause_expected", 32'(cause_q.size()), 32'd1);
        else begin
          e = cause_q.pop_front();
          chk("mon_cause", o_irq_cause, e);
        end
      end
      prev_req = o_irq_req;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a);
    bus_re = 1'b1; bus_addr = a;
    @(negedge clk);
    bus_re = 1'b0;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
  endtask

  task automatic pulse_mret();
    mret = 1'b1;
    @(negedge clk);
    mret = 1'b0;
  endtask

  task automatic wait_req(input int limit, input string name);
    int n;
    n = 0;
    while (!o_irq_req && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, o_irq_req}, 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, o_irq_req}, 32'd0);
    chk("rst_cause", o_irq_cause, 32'd0);
    reset_x = 1'b1;
    rd(5'h0C); chk("rst_mtime_lo", o_bus_rdata, 32'd0);
    rd(5'h04); chk("rst_cmp_lo", o_bus_rdata, 32'hFFFF_FFFF);
    rd(5'h08); chk("rst_cmp_hi", o_bus_rdata, 32'hFFFF_FFFF);
    chk("rst_req_after", {31'd0, o_irq_req}, 32'd0);

    mie_global = 1'b1;
    wr(5'h0C, 32'd0); wr(5'h10, 32'd0); wr(5'h04, 32'd20); wr(5'h08, 32'd0);
    wr(5'h18, 32'h80);
    wait_req(40, "tmr_req");
    chk("tmr_cause", o_irq_cause, 32'h8000_0007);
    rd(5'h0C); chk("tmr_mtime_at_req", o_bus_rdata, 32'd21);
    pulse_ack(); chk("tmr_ack_drop", {31'd0, o_irq_req}, 32'd0);
    repeat (3) @(negedge clk);
    chk("tmr_service_quiet", {31'd0, o_irq_req}, 32'd0);
    pulse_mret(); chk("tmr_mret_idle", {31'd0, o_irq_req}, 32'd0);
    @(negedge clk);
    chk("tmr_refire", {31'd0, o_irq_req}, 32'd1);
    chk("tmr_refire_cause", o_irq_cause, 32'h8000_0007);
    wr(5'h08, 32'hFFFF_FFFF); wr(5'h18, 32'd0);
    @(negedge clk);
    chk("tmr_withdrawn", {31'd0, o_irq_req}, 32'd0);

    mie_global = 1'b0;
    wr(5'h18, 32'h888);
    bus_we = 1'b1; bus_addr = 5'h00; bus_wdata = 32'd1; ext_irq = 4'b0100;
    @(negedge clk);
    bus_we = 1'b0;
    repeat (3) @(negedge clk);
    chk("pri_gated", {31'd0, o_irq_req}, 32'd0);
    mie_global = 1'b1;
    @(negedge clk);
    chk("pri_req", {31'd0, o_irq_req}, 32'd1);
    chk("pri_cause_mei", o_irq_cause, 32'h8000_000B);
    pulse_ack();
    ext_irq = '0;
    wr(5'h14, 32'h4);
    pulse_mret(); chk("pri_mret", {31'd0, o_irq_req}, 32'd0);
    @(negedge clk);
    chk("pri_second", {31'd0, o_irq_req}, 32'd1);
    chk("pri_cause_msi", o_irq_cause, 32'h8000_0003);

    wr(5'h00, 32'd0); chk("wd_hold", {31'd0, o_irq_req}, 32'd1);
    @(negedge clk); chk("wd_drop", {31'd0, o_irq_req}, 32'd0);
    pulse_ack(); chk("wd_ack_ignored", {31'd0, o_irq_req}, 32'd0);
    wr(5'h00, 32'd1);
    @(negedge clk); chk("wd_idle_refire", {31'd0, o_irq_req}, 32'd1);
    wr(5'h00, 32'd0);
    @(negedge clk); chk("wd_clean", {31'd0, o_irq_req}, 32'd0);

    mie_global = 1'b0;
    wr(5'h00, 32'd1);
    repeat (3) @(negedge clk);
    chk("gate_off", {31'd0, o_irq_req}, 32'd0);
    mie_global = 1'b1;
    @(negedge clk);
    chk("gate_on", {31'd0, o_irq_req}, 32'd1);
    chk("gate_cause", o_irq_cause, 32'h8000_0003);
    pulse_ack();
    ext_irq = 4'b0010;
    repeat (4) @(negedge clk);
    chk("svc_hold", {31'd0, o_irq_req}, 32'd0);
    rd(5'h14); chk("svc_pend", o_bus_rdata, 32'h2);
    pulse_mret(); chk("svc_mret", {31'd0, o_irq_req}, 32'd0);
    @(negedge clk);
    chk("svc_after_mret", {31'd0, o_irq_req}, 32'd1);
    chk("svc_cause_mei", o_irq_cause, 32'h8000_000B);
    mie_global = 1'b0;
    pulse_ack();
    ext_irq = '0;
    wr(5'h00, 32'd0); wr(5'h14, 32'hF);
    pulse_mret();
    chk("svc_clean", {31'd0, o_irq_req}, 32'd0);

    repeat (2) @(negedge clk);
    ext_irq = 4'b0001;
    @(negedge clk);
    bus_we = 1'b1; bus_addr = 5'h14; bus_wdata = 32'd1;
    @(negedge clk);
    bus_we = 1'b0;
    rd(5'h14); chk("w1c_edge_wins", o_bus_rdata, 32'h1);
    wr(5'h14, 32'd1);
    rd(5'h14); chk("w1c_clears", o_bus_rdata, 32'h0);
    ext_irq = '0;

    wr(5'h0C, 32'hFFFF_FFFF); wr(5'h10, 32'hFFFF_FFFF);
    rd(5'h0C); chk("wrap_lo_before", o_bus_rdata, 32'hFFFF_FFFF);
    rd(5'h10); chk("wrap_hi_after", o_bus_rdata, 32'h0);

    mie_global = 1'b1;
    wr(5'h00, 32'd1); chk("rq_pre", {31'd0, o_irq_req}, 32'd0);
    @(negedge clk); chk("rq_up", {31'd0, o_irq_req}, 32'd1);
    reset_x = 1'b0;
    @(negedge clk); chk("rst_in_req", {31'd0, o_irq_req}, 32'd0);
    reset_x = 1'b1;
    rd(5'h00); chk("rst_msip", o_bus_rdata, 32'd0);
    rd(5'h18); chk("rst_enable", o_bus_rdata, 32'd0);
    rd(5'h04); chk("rst_cmp_again", o_bus_rdata, 32'hFFFF_FFFF);
    chk("rst_no_req", {31'd0, o_irq_req}, 32'd0);

    for (int c = 0; c < 3000; c++) begin
      reset_x    = ($urandom_range(0, 599) != 0);
      mie_global = ($urandom_range(0, 7) != 0);
      irq_ack    = ($urandom_range(0, 3) == 0);
      mret       = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) ext_irq = N_EXT'($urandom);
      bus_we   = ($urandom_range(0, 3) == 0);
      bus_re   = ($urandom_range(0, 2) == 0);
      bus_addr = 5'($urandom_range(0, 7) * 4);
      case (bus_addr)
        5'h04, 5'h0C: bus_wdata = 32'($urandom_range(0, 400));
        5'h08, 5'h10: bus_wdata = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'd0;
        default:      bus_wdata = 32'($urandom);
      endcase
      @(negedge clk);
    end
    reset_x = 1'b1; bus_we = 1'b0; bus_re = 1'b0; irq_ack = 1'b0; mret = 1'b0;
    repeat (3) @(negedge clk);
    chk("end_rd_q_empty", 32'(rd_q.size()), 32'd0);
    chk("end_cause_q_empty", 32'(cause_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
